// File: rtl/reg_write_scheduler.sv
// Round-robin arbiter sharing one register-bank write port, with bounded burst lock.
// Optional sticky same-address detector enabled by defining WR_COLLISION_CHK_EN.
module reg_write_scheduler #(
    parameter int N        = 32,
    parameter int NREQ     = 4,
    parameter int AW       = 5,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              collision
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [3:0]      lock_cnt, cnt_n;
    logic [NREQ-1:0] grant;
    logic            found;
    int              idx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [N-1:0]    sel_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            ptr      <= PW'(NREQ - 1);
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            lock_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = lock_cnt;
        grant   = '0;
        found   = 1'b0;
        idx     = 0;
        unique case (state)
            ARB: begin
                // search starts one past the last winner
                for (int i = 1; i <= NREQ; i++) begin
                    idx = (int'(ptr) + i) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        ptr_n      = PW'(idx);
                    end
                end
                if (found && req_lock[ptr_n] && (LOCK_MAX > 1)) begin
                    state_n = LOCKED;
                    cnt_n   = 4'd1;
                end
            end
            LOCKED: begin
                if (req_valid[ptr]) begin
                    grant[ptr] = 1'b1;
                    cnt_n      = lock_cnt + 4'd1;
                    if (!req_lock[ptr] || cnt_n >= 4'(LOCK_MAX)) begin
                        state_n = ARB;
                        cnt_n   = '0;
                    end
                end else begin
                    state_n = ARB;
                    cnt_n   = '0;
                end
            end
            default: state_n = ARB;
        endcase
    end

    assign req_ready = reset ? '0 : grant;
    assign xfer      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*N +: N];
            end
        end
    end

    // register 0 is hardwired: accepted, but never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= xfer && (sel_addr != '0);
            if (xfer && (sel_addr != '0)) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

`ifdef WR_COLLISION_CHK_EN
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    req_addr[i*AW +: AW] == req_addr[j*AW +: AW] &&
                    req_addr[i*AW +: AW] != '0)
                    hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) collision <= 1'b0;
        else       collision <= collision | hit;
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed-vector bench for reg_write_scheduler (N=32, NREQ=4, AW=5, LOCK_MAX=4).
module tb_reg_write_scheduler;
    localparam int N = 32;
    localparam int NREQ = 4;
    localparam int AW = 5;

`ifdef WR_COLLISION_CHK_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [N-1:0]      wr_data;
    logic              collision;

    int total = 0;
    int bad = 0;

    reg_write_scheduler #(.N(N), .NREQ(NREQ), .AW(AW), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [AW-1:0] a, input logic [N-1:0] d);
        req_valid[i] = v;
        req_lock[i]  = l;
        req_addr[i*AW +: AW] = a;
        req_data[i*N +: N]   = d;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] exp3 [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
    logic [AW-1:0] adr3 [6] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd6, 5'd5};

    initial begin
        reset = 1'b1;
        clear_req();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 1'b0, AW'(i + 1), 32'hA0 + 32'(i));
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_coll", 32'(collision), 32'h0);
        reset = 1'b0;

        // round robin over four always-valid requesters
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check("rr_wr_en", 32'(wr_en), 32'h1);
            check("rr_wr_addr", 32'(wr_addr), 32'((k % 4) + 1));
            check("rr_wr_data", wr_data, 32'hA0 + 32'(k % 4));
        end

        // idle cycle holds address, then single write from req 2
        clear_req();
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("idle_wr_en", 32'(wr_en), 32'h0);
        check("idle_hold", 32'(wr_addr), 32'h2);
        set_req(2, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF);
        #1;
        check("one_ready", 32'(req_ready), 32'h4);
        tick();
        check("one_wr_en", 32'(wr_en), 32'h1);
        check("one_wr_addr", 32'(wr_addr), 32'h7);
        check("one_wr_data", wr_data, 32'hDEADBEEF);
        clear_req();
        #1;
        check("one_ready_off", 32'(req_ready), 32'h0);
        tick();
        check("one_wr_en_off", 32'(wr_en), 32'h0);
        check("one_data_hold", wr_data, 32'hDEADBEEF);

        // bounded lock: req1 held for 4 grants, then req3 once
        do_reset();
        set_req(1, 1'b1, 1'b1, 5'd5, 32'h11);
        set_req(3, 1'b1, 1'b0, 5'd6, 32'h33);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("lock_ready", 32'(req_ready), 32'(exp3[k]));
            tick();
            check("lock_wr_addr", 32'(wr_addr), 32'(adr3[k]));
        end

        // zero-register write is accepted but not performed
        clear_req();
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd0, 32'h1234);
        #1;
        check("zero_ready", 32'(req_ready), 32'h1);
        tick();
        check("zero_wr_en", 32'(wr_en), 32'h0);
        set_req(0, 1'b1, 1'b1, 5'd3, 32'h55);
        #1;
        check("burst_ready0", 32'(req_ready), 32'h1);
        tick();
        check("burst_wr_en", 32'(wr_en), 32'h1);
        check("burst_wr_addr", 32'(wr_addr), 32'h3);
        #1;
        check("burst_ready1", 32'(req_ready), 32'h1);
        reset = 1'b1;
        #1;
        check("async_ready", 32'(req_ready), 32'h0);
        check("async_wr_en", 32'(wr_en), 32'h0);
        check("async_wr_addr", 32'(wr_addr), 32'h0);
        check("async_wr_data", wr_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd3, 32'h55);
        set_req(1, 1'b1, 1'b0, 5'd8, 32'h66);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        check("no_coll_yet", 32'(collision), 32'h0);

        // same nonzero address from two requesters
        clear_req();
        set_req(0, 1'b1, 1'b0, 5'd9, 32'h1);
        set_req(2, 1'b1, 1'b0, 5'd9, 32'h2);
        tick();
        check("coll_set", 32'(collision), 32'(COLL_EXP));
        clear_req();
        tick();
        tick();
        check("coll_sticky", 32'(collision), 32'(COLL_EXP));
        do_reset();
        check("coll_rst", 32'(collision), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
